regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the single-write-port integer register file. Adds a second write port for long-latency units, a per-register busy scoreboard for issue/hazard detection, a generic debug read port and optional same-cycle write bypass.
- Sits between decode (reads, claims) and the writeback stages: the in-order pipeline writes on port 0, multicycle mul/div/mem writes on port 1.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; must be a power of two and at least 2.
- AW, 5, register index width; equals log2(NREG).
- SP_IDX, 2, index of the register loaded with SP_INIT on reset.
- SP_INIT, 32'h2ffc, reset value of register SP_IDX (XLEN bits).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- rs1  in  AW  read address A.
- rs2  in  AW  read address B.
- rs1_dout  out  XLEN  asynchronous read data A.
- rs2_dout  out  XLEN  asynchronous read data B.
- rs1_busy  out  1  scoreboard bit for rs1, combinational.
- rs2_busy  out  1  scoreboard bit for rs2, combinational.
- we0  in  1  write enable, port 0 (pipeline writeback).
- wd0_rd  in  AW  destination index, port 0.
- wd0_din  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (long-latency writeback).
- wd1_rd  in  AW  destination index, port 1.
- wd1_din  in  XLEN  write data, port 1.
- claim_en  in  1  issue of a long-latency op: mark claim_rd busy.
- claim_rd  in  AW  register to mark busy.
- dbg_addr  in  AW  debug/test read address.
- dbg_dout  out  XLEN  asynchronous debug read data (no bypass).
- sb_err  out  1  sticky error: claim to an already-busy register, or port-1 write to a non-busy register.

Behaviour:
- Reset (synchronous, dominates every other input that cycle):
  - All registers become 0 except reg[SP_IDX] = SP_INIT.
  - busy[] all 0; sb_err = 0.
  - Reset takes effect at the edge where it is sampled. Any in-flight claim or write on that edge is discarded.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and claims to index 0 are ignored and never raise sb_err.
- Reads:
  - rs*_dout = reg[rs*] combinationally, subject to the optional bypass below.
  - dbg_dout always returns the stored value.
- Writes (posedge):
  - weN && wdN_rd != 0 -> reg[wdN_rd] <= wdN_din.
  - Both ports enabled with the same rd: port 1 wins and port 0's data is dropped.
- Scoreboard (posedge, evaluated in this order on the same edge):
  - Clear: we1 && wd1_rd != 0 -> busy[wd1_rd] <= 0. Port-0 writes never touch busy.
  - Set: claim_en && claim_rd != 0 -> busy[claim_rd] <= 1. Set overrides a same-cycle clear of the same index, so back-to-back reuse of a destination stays busy.
- Errors (sticky until reset):
  - claim_en to a register that is busy before the edge and not being cleared on that edge -> sb_err <= 1; busy stays 1.
  - we1 to a register that is not busy -> sb_err <= 1; the write is still performed.
- Latency:
  - Written data is visible on rs*_dout from the cycle after the write edge (without bypass).
  - The busy bit changes the cycle after the claim/clear edge.
- Arithmetic: none; indices are unsigned AW bits. Out-of-range indices cannot occur since NREG = 2^AW.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined:
  - rs*_dout is forwarded combinationally from an enabled, nonzero write port whose rd matches the read address, in the same cycle. If both ports match, port 1 wins.
  - rs*_busy reads 0 when we1 is clearing that index in the same cycle, unless claim_en is setting the same index.
- Undefined: no forwarding; rs*_dout and rs*_busy reflect state registered before the edge only.
- dbg_dout is unaffected in both builds.

Test Plan:
- Reset release -> dbg_addr=2 gives 32'h2ffc; dbg_addr=17 gives 0; all busy bits 0; sb_err=0.
- we0, wd0_rd=5, wd0_din=32'hdeadbeef -> rs1=5 reads 32'hdeadbeef next cycle. Same cycle: old value without bypass, 32'hdeadbeef with REGFILE_SB_BYPASS_EN.
- we0 and we1 both to rd=9 (data 32'h11 / 32'h22, reg 9 claimed beforehand) -> reg9 = 32'h22; busy[9] = 0; sb_err = 0.
- claim_en rd=7, then we1 rd=7 plus claim_en rd=7 on the same edge -> busy[7] stays 1, sb_err=0; a further claim rd=7 with no clear -> sb_err=1.
- Writes/claims to rd=0 with data 32'hffffffff -> rs1=0 reads 0, busy 0, sb_err 0; we1 to non-busy rd=3 -> sb_err=1 and reg3 updated.
- Reset asserted the same cycle as we0 rd=4 and claim rd=4 -> reg4 = 0, busy[4] = 0, reg2 = 32'h2ffc, sb_err cleared.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: register file read/write/claim/debug bus
interface regfile_sb_if #(parameter int XLEN = 32, parameter int AW = 5);
  logic [AW-1:0]   rs1, rs2, wd0_rd, wd1_rd, claim_rd, dbg_addr;
  logic [XLEN-1:0] rs1_dout, rs2_dout, wd0_din, wd1_din, dbg_dout;
  logic            rs1_busy, rs2_busy, we0, we1, claim_en, sb_err;
  modport master (
    output rs1, rs2, we0, wd0_rd, wd0_din, we1, wd1_rd, wd1_din, claim_en, claim_rd, dbg_addr,
    input  rs1_dout, rs2_dout, rs1_busy, rs2_busy, dbg_dout, sb_err
  );
  modport slave (
    input  rs1, rs2, we0, wd0_rd, wd0_din, we1, wd1_rd, wd1_din, claim_en, claim_rd, dbg_addr,
    output rs1_dout, rs2_dout, rs1_busy, rs2_busy, dbg_dout, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: two-write-port register file with busy scoreboard; REGFILE_SB_BYPASS_EN enables same-cycle forwarding
module regfile_sb #(
  parameter int              XLEN    = 32,
  parameter int              NREG    = 32,
  parameter int              AW      = 5,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 'h2ffc
) (
  input logic        clk,
  input logic        reset,
  regfile_sb_if.slave bus
);
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            err;
  logic            wr0, wr1, clm, err_claim, err_wr1;
  assign wr0 = bus.we0 && bus.wd0_rd != '0;
  assign wr1 = bus.we1 && bus.wd1_rd != '0;
  assign clm = bus.claim_en && bus.claim_rd != '0;
  // a claim is only illegal if the register stays busy through this edge
  assign err_claim = clm && busy[bus.claim_rd] && !(wr1 && bus.wd1_rd == bus.claim_rd);
  assign err_wr1 = wr1 && !busy[bus.wd1_rd];
  // storage, scoreboard and sticky error; later assignments give port 1 and claims priority
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i != 0 && i == SP_IDX) ? SP_INIT : '0;
      busy <= '0;
      err  <= 1'b0;
    end else begin
      if (wr0) regs[bus.wd0_rd] <= bus.wd0_din;
      if (wr1) regs[bus.wd1_rd] <= bus.wd1_din;
      if (wr1) busy[bus.wd1_rd] <= 1'b0;
      if (clm) busy[bus.claim_rd] <= 1'b1;
      err <= err | err_claim | err_wr1;
    end
  end
  assign bus.rs1_dout = (BYP && wr1 && bus.wd1_rd == bus.rs1) ? bus.wd1_din :
                        (BYP && wr0 && bus.wd0_rd == bus.rs1) ? bus.wd0_din : regs[bus.rs1];
  assign bus.rs2_dout = (BYP && wr1 && bus.wd1_rd == bus.rs2) ? bus.wd1_din :
                        (BYP && wr0 && bus.wd0_rd == bus.rs2) ? bus.wd0_din : regs[bus.rs2];
  assign bus.rs1_busy = busy[bus.rs1] &&
                        !(BYP && wr1 && bus.wd1_rd == bus.rs1 && !(clm && bus.claim_rd == bus.rs1));
  assign bus.rs2_busy = busy[bus.rs2] &&
                        !(BYP && wr1 && bus.wd1_rd == bus.rs2 && !(clm && bus.claim_rd == bus.rs2));
  assign bus.dbg_dout = regs[bus.dbg_addr];
  assign bus.sb_err   = err;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb
module tb_regfile_sb;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  regfile_sb_if #(.XLEN(32), .AW(5)) bus ();
  regfile_sb dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.we0 = 0; bus.we1 = 0; bus.claim_en = 0;
    bus.wd0_rd = 0; bus.wd1_rd = 0; bus.claim_rd = 0;
    bus.wd0_din = 0; bus.wd1_din = 0;
  endtask
  initial begin
    idle();
    bus.rs1 = 0; bus.rs2 = 0; bus.dbg_addr = 0;
    tick(); tick();
    reset = 0;
    bus.dbg_addr = 2; #1 chk("rst_sp", bus.dbg_dout, 32'h2ffc);
    bus.dbg_addr = 17; #1 chk("rst_r17", bus.dbg_dout, 0);
    bus.rs1 = 2; #1 chk("rst_rs1_sp", bus.rs1_dout, 32'h2ffc);
    for (int i = 0; i < 32; i++) begin
      bus.rs2 = 5'(i); #1 chk("rst_busy", {31'b0, bus.rs2_busy}, 0);
    end
    chk("rst_err", {31'b0, bus.sb_err}, 0);
    bus.we0 = 1; bus.wd0_rd = 5; bus.wd0_din = 32'hdeadbeef; bus.rs1 = 5; bus.dbg_addr = 5;
    #1 chk("wr0_same", bus.rs1_dout, BYP ? 32'hdeadbeef : 32'h0);
    chk("wr0_dbg_same", bus.dbg_dout, 0);
    tick(); idle();
    #1 chk("wr0_next", bus.rs1_dout, 32'hdeadbeef);
    chk("wr0_dbg_next", bus.dbg_dout, 32'hdeadbeef);
    bus.claim_en = 1; bus.claim_rd = 9; bus.rs2 = 9;
    #1 chk("clm9_pre", {31'b0, bus.rs2_busy}, 0);
    tick(); idle();
    #1 chk("clm9_busy", {31'b0, bus.rs2_busy}, 1);
    bus.we0 = 1; bus.wd0_rd = 9; bus.wd0_din = 32'h11;
    bus.we1 = 1; bus.wd1_rd = 9; bus.wd1_din = 32'h22; bus.rs1 = 9;
    #1 chk("dual_same", bus.rs1_dout, BYP ? 32'h22 : 32'h0);
    chk("dual_busy_same", {31'b0, bus.rs2_busy}, BYP ? 0 : 1);
    tick(); idle(); bus.dbg_addr = 9;
    #1 chk("dual_r9", bus.dbg_dout, 32'h22);
    chk("dual_busy", {31'b0, bus.rs2_busy}, 0);
    chk("dual_err", {31'b0, bus.sb_err}, 0);
    bus.claim_en = 1; bus.claim_rd = 7; bus.rs1 = 7;
    tick(); idle();
    #1 chk("clm7_busy", {31'b0, bus.rs1_busy}, 1);
    bus.we1 = 1; bus.wd1_rd = 7; bus.wd1_din = 32'h77; bus.claim_en = 1; bus.claim_rd = 7;
    #1 chk("reuse7_same", {31'b0, bus.rs1_busy}, 1);
    tick(); idle(); bus.dbg_addr = 7;
    #1 chk("reuse7_busy", {31'b0, bus.rs1_busy}, 1);
    chk("reuse7_err", {31'b0, bus.sb_err}, 0);
    chk("reuse7_data", bus.dbg_dout, 32'h77);
    bus.claim_en = 1; bus.claim_rd = 7;
    tick(); idle();
    #1 chk("dblclm_err", {31'b0, bus.sb_err}, 1);
    chk("dblclm_busy", {31'b0, bus.rs1_busy}, 1);
    reset = 1; bus.we0 = 1; bus.wd0_rd = 4; bus.wd0_din = 32'h44; bus.claim_en = 1; bus.claim_rd = 4;
    tick(); reset = 0; idle();
    bus.dbg_addr = 4; bus.rs1 = 4; bus.rs2 = 7;
    #1 chk("rstw_r4", bus.dbg_dout, 0);
    chk("rstw_busy4", {31'b0, bus.rs1_busy}, 0);
    chk("rstw_busy7", {31'b0, bus.rs2_busy}, 0);
    chk("rstw_err", {31'b0, bus.sb_err}, 0);
    bus.dbg_addr = 2; #1 chk("rstw_sp", bus.dbg_dout, 32'h2ffc);
    bus.dbg_addr = 5; #1 chk("rstw_r5", bus.dbg_dout, 0);
    bus.we0 = 1; bus.wd0_rd = 0; bus.wd0_din = 32'hffffffff;
    bus.we1 = 1; bus.wd1_rd = 0; bus.wd1_din = 32'hffffffff;
    bus.claim_en = 1; bus.claim_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    #1 chk("r0_same", bus.rs1_dout, 0);
    tick(); idle();
    #1 chk("r0_read", bus.rs1_dout, 0);
    chk("r0_busy", {31'b0, bus.rs2_busy}, 0);
    chk("r0_err", {31'b0, bus.sb_err}, 0);
    bus.we1 = 1; bus.wd1_rd = 3; bus.wd1_din = 32'h33;
    tick(); idle(); bus.dbg_addr = 3; bus.rs1 = 3;
    #1 chk("nb_err", {31'b0, bus.sb_err}, 1);
    chk("nb_data", bus.dbg_dout, 32'h33);
    chk("nb_busy", {31'b0, bus.rs1_busy}, 0);
    tick();
    chk("err_sticky", {31'b0, bus.sb_err}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
